// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the clock set controller and the button/timebase/counter side.
// The slave modport is the controller's view; master is the surrounding datapath.
interface clock_set_ctrl_if;
    logic       EN1HZ;
    logic       SIG2HZ;
    logic       MODE;
    logic       UP;
    logic       SECEN;
    logic       SECCLR;
    logic       MINEN;
    logic       HOUREN;
    logic       TBRST;
    logic       BLANK_HOUR;
    logic       BLANK_MIN;
    logic       BLANK_SEC;
    logic [1:0] STATE;

    modport master (
        output EN1HZ, SIG2HZ, MODE, UP,
        input  SECEN, SECCLR, MINEN, HOUREN, TBRST,
        input  BLANK_HOUR, BLANK_MIN, BLANK_SEC, STATE
    );

    modport slave (
        input  EN1HZ, SIG2HZ, MODE, UP,
        output SECEN, SECCLR, MINEN, HOUREN, TBRST,
        output BLANK_HOUR, BLANK_MIN, BLANK_SEC, STATE
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Mode and time-set sequencer for the 24-hour clock: free-run vs. manual set of
// hours/minutes/seconds, with UP auto-repeat, idle timeout and field blinking.
module clock_set_ctrl #(
    parameter int REPEAT_DELAY = 4,
    parameter int TIMEOUT      = 10
) (
    input  logic             CLK,
    input  logic             RST,
    clock_set_ctrl_if.slave  bus
);
    localparam logic [1:0] NORMAL   = 2'b00;
    localparam logic [1:0] SET_HOUR = 2'b01;
    localparam logic [1:0] SET_MIN  = 2'b10;
    localparam logic [1:0] SET_SEC  = 2'b11;

    localparam logic [3:0] REP_MAX   = 4'(REPEAT_DELAY);
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state, state_nx;
    logic       mode_d, up_d, sig_d;
    logic [3:0] rep_cnt;
    logic [7:0] idle_cnt;
    logic       secclr_q, minen_q, houren_q, tbrst_q;

    logic mode_pe, up_pe, tgl, in_set, rep, inc, timeout;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mode_pe  = bus.MODE & ~mode_d;
        up_pe    = bus.UP & ~up_d;
        tgl      = bus.SIG2HZ ^ sig_d;
        in_set   = (state != NORMAL);
        rep      = tgl & bus.UP & (rep_cnt == REP_MAX);
        inc      = (up_pe | rep) & in_set & ~mode_pe;
        timeout  = in_set & bus.EN1HZ & (idle_cnt == IDLE_LAST);
        state_nx = state;
        // Timeout takes priority over MODE so a simultaneous press cannot skip past NORMAL.
        case (state)
            NORMAL:   if (mode_pe) state_nx = SET_HOUR;
            SET_HOUR: if (timeout) state_nx = NORMAL; else if (mode_pe) state_nx = SET_MIN;
            SET_MIN:  if (timeout) state_nx = NORMAL; else if (mode_pe) state_nx = SET_SEC;
            SET_SEC:  if (timeout | mode_pe) state_nx = NORMAL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= NORMAL;
            mode_d   <= 1'b1;   // a button held through reset must not count as a press
            up_d     <= 1'b1;
            sig_d    <= 1'b0;
            rep_cnt  <= '0;
            idle_cnt <= '0;
            secclr_q <= 1'b0;
            minen_q  <= 1'b0;
            houren_q <= 1'b0;
            tbrst_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            mode_d   <= bus.MODE;
            up_d     <= bus.UP;
            sig_d    <= bus.SIG2HZ;
            houren_q <= inc & (state == SET_HOUR);
            minen_q  <= inc & (state == SET_MIN);
            secclr_q <= inc & (state == SET_SEC);
            tbrst_q  <= in_set & (state_nx == NORMAL);

            if (up_pe | ~bus.UP | ~in_set)
                rep_cnt <= '0;
            else if (tgl && rep_cnt != REP_MAX)
                rep_cnt <= rep_cnt + 4'd1;

            if (mode_pe | inc | ~in_set)
                idle_cnt <= '0;
            else if (bus.EN1HZ)
                idle_cnt <= idle_cnt + 8'd1;
        end
    end

    assign bus.STATE      = state;
    assign bus.SECEN      = bus.EN1HZ & (state == NORMAL);
    assign bus.SECCLR     = secclr_q;
    assign bus.MINEN      = minen_q;
    assign bus.HOUREN     = houren_q;
    assign bus.TBRST      = tbrst_q;
    assign bus.BLANK_HOUR = (state == SET_HOUR) & bus.SIG2HZ & ~bus.UP;
    assign bus.BLANK_MIN  = (state == SET_MIN)  & bus.SIG2HZ & ~bus.UP;
    assign bus.BLANK_SEC  = (state == SET_SEC)  & bus.SIG2HZ & ~bus.UP;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed and randomized bench for clock_set_ctrl; a cycle-level reference model
// built from the behavioural rules predicts every output.
module tb_clock_set_ctrl;
    localparam int RD  = 4;
    localparam int TMO = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    clock_set_ctrl_if bus();

    clock_set_ctrl #(.REPEAT_DELAY(RD), .TIMEOUT(TMO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks_total  = 0;
    int checks_passed = 0;

    // reference model: state index 0 NORMAL, 1 hour, 2 min, 3 sec
    bit m_valid = 0;
    int m_st, m_rep, m_idle;
    bit m_mode_d, m_up_d, m_sig_d;
    bit m_secclr, m_minen, m_houren, m_tbrst;

    int cnt_houren, cnt_minen, cnt_secclr, cnt_tbrst, cnt_secen, cnt_blank_min;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_counts();
        cnt_houren = 0; cnt_minen = 0; cnt_secclr = 0;
        cnt_tbrst = 0; cnt_secen = 0; cnt_blank_min = 0;
    endtask

    task automatic tick();
        bit rst_s, en_s, up_s, mpe, upe, tg, in_set, rp, inc, tmo;
        int nxt;
        #1;
        if (m_valid) begin
            check("SECEN",      bus.SECEN,      32'(bus.EN1HZ && m_st == 0));
            check("BLANK_HOUR", bus.BLANK_HOUR, 32'(m_st == 1 && bus.SIG2HZ && !bus.UP));
            check("BLANK_MIN",  bus.BLANK_MIN,  32'(m_st == 2 && bus.SIG2HZ && !bus.UP));
            check("BLANK_SEC",  bus.BLANK_SEC,  32'(m_st == 3 && bus.SIG2HZ && !bus.UP));
        end
        if (bus.SECEN === 1'b1) cnt_secen++;
        if (bus.BLANK_MIN === 1'b1) cnt_blank_min++;

        rst_s  = RST;
        en_s   = bus.EN1HZ;
        up_s   = bus.UP;
        mpe    = bus.MODE && !m_mode_d;
        upe    = bus.UP && !m_up_d;
        tg     = bus.SIG2HZ != m_sig_d;
        in_set = m_st != 0;
        rp     = tg && up_s && (m_rep == RD);
        inc    = (upe || rp) && in_set && !mpe;
        tmo    = in_set && en_s && (m_idle + 1 == TMO);
        nxt    = tmo ? 0 : (mpe ? (m_st + 1) % 4 : m_st);

        @(posedge CLK);
        if (rst_s) begin
            m_st = 0; m_rep = 0; m_idle = 0;
            m_mode_d = 1; m_up_d = 1; m_sig_d = 0;
            m_secclr = 0; m_minen = 0; m_houren = 0; m_tbrst = 0;
            m_valid = 1;
        end else begin
            m_houren = inc && m_st == 1;
            m_minen  = inc && m_st == 2;
            m_secclr = inc && m_st == 3;
            m_tbrst  = in_set && nxt == 0;
            if (upe || !up_s || !in_set) m_rep = 0;
            else if (tg) m_rep = (m_rep + 1 > RD) ? RD : m_rep + 1;
            if (mpe || inc || !in_set) m_idle = 0;
            else if (en_s) m_idle = m_idle + 1;
            m_mode_d = bus.MODE; m_up_d = up_s; m_sig_d = bus.SIG2HZ;
            m_st = nxt;
        end
        #1;
        if (m_valid) begin
            check("STATE",  bus.STATE,  32'(m_st));
            check("HOUREN", bus.HOUREN, 32'(m_houren));
            check("MINEN",  bus.MINEN,  32'(m_minen));
            check("SECCLR", bus.SECCLR, 32'(m_secclr));
            check("TBRST",  bus.TBRST,  32'(m_tbrst));
        end
        if (bus.HOUREN === 1'b1) cnt_houren++;
        if (bus.MINEN  === 1'b1) cnt_minen++;
        if (bus.SECCLR === 1'b1) cnt_secclr++;
        if (bus.TBRST  === 1'b1) cnt_tbrst++;
    endtask

    task automatic press_mode();
        bus.MODE = 1'b1; tick();
        bus.MODE = 1'b0; tick();
    endtask

    task automatic pulse_en1hz();
        bus.EN1HZ = 1'b1; tick();
        bus.EN1HZ = 1'b0; repeat (3) tick();
    endtask

    initial begin
        bus.EN1HZ = 0; bus.SIG2HZ = 0; bus.MODE = 1; bus.UP = 1;

        // reset with both buttons held, then release
        RST = 1; repeat (3) tick();
        RST = 0; clear_counts(); repeat (3) tick();
        check("reset_state", bus.STATE, 0);
        bus.MODE = 0; bus.UP = 0; repeat (2) tick();
        check("reset_no_change", bus.STATE, 0);
        check("reset_no_inc", cnt_houren + cnt_minen + cnt_secclr + cnt_tbrst, 0);

        // walk through the set states, 100 cycles apart
        for (int s = 1; s <= 3; s++) begin
            bus.MODE = 1; tick();
            check("mode_step", bus.STATE, s);
            bus.MODE = 0; repeat (99) tick();
        end
        bus.MODE = 1; tick();
        check("mode_wrap", bus.STATE, 0);
        check("wrap_tbrst", bus.TBRST, 1);
        bus.MODE = 0; tick();
        check("tbrst_one_cycle", bus.TBRST, 0);

        // SET_HOUR: one UP press, then EN1HZ pulses (third one times out)
        press_mode();
        clear_counts();
        bus.UP = 1; tick();
        check("houren_latency", bus.HOUREN, 1);
        tick();
        bus.UP = 0; tick();
        repeat (3) pulse_en1hz();
        check("houren_count", cnt_houren, 1);
        check("hour_no_minen", cnt_minen + cnt_secclr, 0);
        check("hour_no_secen", cnt_secen, 0);
        check("hour_timeout_state", bus.STATE, 0);
        check("hour_timeout_tbrst", cnt_tbrst, 1);

        // SET_MIN: UP held across 8 toggles -> press + 4 repeats
        press_mode(); press_mode();
        clear_counts();
        bus.UP = 1; repeat (3) tick();
        for (int k = 0; k < 8; k++) begin
            bus.SIG2HZ = ~bus.SIG2HZ; repeat (3) tick();
        end
        check("minen_repeat_count", cnt_minen, 5);
        check("blank_min_held", cnt_blank_min, 0);
        bus.UP = 0; tick();
        bus.SIG2HZ = ~bus.SIG2HZ; tick();
        check("blank_min_released", bus.BLANK_MIN, 1);
        bus.SIG2HZ = ~bus.SIG2HZ; tick();
        check("blank_min_low", bus.BLANK_MIN, 0);

        // SET_SEC: UP after 2nd EN1HZ restarts the idle count
        press_mode();
        check("in_set_sec", bus.STATE, 3);
        repeat (2) pulse_en1hz();
        bus.UP = 1; tick();
        check("secclr_pulse", bus.SECCLR, 1);
        bus.UP = 0; tick();
        repeat (2) pulse_en1hz();
        check("sec_not_yet_timeout", bus.STATE, 3);
        bus.EN1HZ = 1; tick();
        check("sec_timeout_state", bus.STATE, 0);
        check("sec_timeout_tbrst", bus.TBRST, 1);
        bus.EN1HZ = 0; tick();
        check("sec_tbrst_width", bus.TBRST, 0);
        bus.EN1HZ = 1; #1;
        check("secen_normal", bus.SECEN, 1);
        tick(); bus.EN1HZ = 0; tick();

        // MODE and UP together in SET_HOUR: MODE wins
        press_mode();
        bus.MODE = 1; bus.UP = 1; tick();
        check("mode_wins_state", bus.STATE, 2);
        check("mode_wins_houren", bus.HOUREN, 0);
        bus.MODE = 0; bus.UP = 0; tick();

        // reset mid-set: back to NORMAL, no TBRST
        RST = 1; tick();
        check("midset_reset_state", bus.STATE, 0);
        check("midset_reset_tbrst", bus.TBRST, 0);
        RST = 0; tick();

        // timeout coincident with MODE in SET_MIN
        press_mode(); press_mode();
        repeat (2) pulse_en1hz();
        bus.EN1HZ = 1; bus.MODE = 1; tick();
        check("timeout_beats_mode", bus.STATE, 0);
        bus.EN1HZ = 0; bus.MODE = 0; tick();

        // randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.MODE = ~bus.MODE;
            if ($urandom_range(0, 9) == 0)  bus.UP = ~bus.UP;
            if ($urandom_range(0, 5) == 0)  bus.SIG2HZ = ~bus.SIG2HZ;
            bus.EN1HZ = ($urandom_range(0, 15) == 0);
            RST = ($urandom_range(0, 799) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
